// File: rtl/serv_dmem_responder.sv
// Memory-side responder for the serv split ca/dm/rd data-memory interface, backed by a word RAM.
// Define RESP_STALL_EN to inject bounded LFSR-driven ready stalls for handshake stress testing.
module serv_dmem_responder #(
    parameter int unsigned AW        = 10,
    parameter int unsigned DEPTH     = 4,
    parameter string       INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_ca_cmd,
    input  logic [31:0] i_ca_adr,
    input  logic        i_ca_vld,
    output logic        o_ca_rdy,
    input  logic [31:0] i_dm_dat,
    input  logic [3:0]  i_dm_msk,
    input  logic        i_dm_vld,
    output logic        o_dm_rdy,
    output logic [31:0] o_rd_dat,
    output logic        o_rd_vld,
    input  logic        i_rd_rdy
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRdq, StWpend} state_e;

    logic [31:0]   mem [2**AW];
    logic [AW-1:0] fifo_q [DEPTH];

    state_e          state_q, state_d;
    logic            live_q;
    logic            wa_full_q, wa_full_d;
    logic [AW-1:0]   wa_idx_q, wa_idx_d;
    logic            wd_full_q, wd_full_d;
    logic [31:0]     wd_dat_q, wd_dat_d;
    logic [3:0]      wd_msk_q, wd_msk_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic            rd_vld_q, rd_vld_d;
    logic [31:0]     rd_dat_q;

    logic [AW-1:0] ca_idx;
    logic          ca_rdy_raw, dm_rdy_raw;
    logic          ca_stall, dm_stall, pop_stall;
    logic          ca_hs, dm_hs, rd_hs, wr_hs, push, pop_ok, pop, commit;
    logic [AW-1:0] cm_idx;
    logic [31:0]   cm_dat;
    logic [3:0]    cm_msk;
    logic          unused_adr;

    assign ca_idx     = i_ca_adr[AW+1:2];
    assign unused_adr = ^{i_ca_adr[31:AW+2], i_ca_adr[1:0]};

    // Writes wait for every earlier read to have sampled the RAM; reads wait for WA to drain.
    assign ca_rdy_raw = !wa_full_q && (out_cnt_q < DepthC) && (!i_ca_cmd || fifo_cnt_q == '0);
    assign dm_rdy_raw = !wd_full_q;

    assign o_ca_rdy = live_q && ca_rdy_raw && !ca_stall;
    assign o_dm_rdy = live_q && dm_rdy_raw && !dm_stall;
    assign o_rd_vld = rd_vld_q;
    assign o_rd_dat = rd_dat_q;

    assign ca_hs  = i_ca_vld && o_ca_rdy;
    assign dm_hs  = i_dm_vld && o_dm_rdy;
    assign rd_hs  = rd_vld_q && i_rd_rdy;
    assign wr_hs  = ca_hs && i_ca_cmd;
    assign push   = ca_hs && !i_ca_cmd;
    assign pop_ok = (state_q == StRdq) && (fifo_cnt_q != '0) && (!rd_vld_q || i_rd_rdy);
    assign pop    = pop_ok && !pop_stall;

    assign commit = (wa_full_q || wr_hs) && (wd_full_q || dm_hs);
    assign cm_idx = wa_full_q ? wa_idx_q : ca_idx;
    assign cm_dat = wd_full_q ? wd_dat_q : i_dm_dat;
    assign cm_msk = wd_full_q ? wd_msk_q : i_dm_msk;

`ifdef RESP_STALL_EN
    logic [7:0] lfsr_q;
    logic       ca_prev_rdy_q, ca_prev_hs_q, dm_prev_rdy_q, dm_prev_hs_q;
    logic [1:0] ca_run_q, dm_run_q, pop_run_q;

    // A stall may only start where the ready was already low or just completed a handshake.
    assign ca_stall  = lfsr_q[0] && (ca_run_q != 2'd2) && !(ca_prev_rdy_q && !ca_prev_hs_q);
    assign dm_stall  = lfsr_q[3] && (dm_run_q != 2'd2) && !(dm_prev_rdy_q && !dm_prev_hs_q);
    assign pop_stall = lfsr_q[6] && (pop_run_q != 2'd2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q        <= 8'hA5;
            ca_prev_rdy_q <= 1'b0;
            ca_prev_hs_q  <= 1'b0;
            dm_prev_rdy_q <= 1'b0;
            dm_prev_hs_q  <= 1'b0;
            ca_run_q      <= 2'd0;
            dm_run_q      <= 2'd0;
            pop_run_q     <= 2'd0;
        end else begin
            lfsr_q        <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            ca_prev_rdy_q <= o_ca_rdy;
            ca_prev_hs_q  <= ca_hs;
            dm_prev_rdy_q <= o_dm_rdy;
            dm_prev_hs_q  <= dm_hs;
            ca_run_q      <= ca_stall ? ca_run_q + 2'd1 : 2'd0;
            dm_run_q      <= dm_stall ? dm_run_q + 2'd1 : 2'd0;
            pop_run_q     <= pop_stall ? pop_run_q + 2'd1 : 2'd0;
        end
    end
`else
    assign ca_stall  = 1'b0;
    assign dm_stall  = 1'b0;
    assign pop_stall = 1'b0;
`endif

    always_comb begin
        wa_full_d  = wa_full_q;
        wa_idx_d   = wa_idx_q;
        wd_full_d  = wd_full_q;
        wd_dat_d   = wd_dat_q;
        wd_msk_d   = wd_msk_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
        out_cnt_d  = out_cnt_q + CntW'(push) - CntW'(rd_hs);
        rd_vld_d   = rd_vld_q;

        if (commit) begin
            wa_full_d = 1'b0;
            wd_full_d = 1'b0;
        end else begin
            if (wr_hs) begin
                wa_full_d = 1'b1;
                wa_idx_d  = ca_idx;
            end
            if (dm_hs) begin
                wd_full_d = 1'b1;
                wd_dat_d  = i_dm_dat;
                wd_msk_d  = i_dm_msk;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

        if (pop) begin
            rd_vld_d = 1'b1;
        end else if (rd_hs) begin
            rd_vld_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (push) begin
                    state_d = StRdq;
                end else if (wa_full_d || wd_full_d) begin
                    state_d = StWpend;
                end
            end
            StRdq: begin
                if (out_cnt_d == '0) begin
                    state_d = (wa_full_d || wd_full_d) ? StWpend : StIdle;
                end
            end
            StWpend: begin
                // A lone early dm beat does not block reads.
                if (push) begin
                    state_d = StRdq;
                end else if (!wa_full_d && !wd_full_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            live_q     <= 1'b0;
            wa_full_q  <= 1'b0;
            wa_idx_q   <= '0;
            wd_full_q  <= 1'b0;
            wd_dat_q   <= '0;
            wd_msk_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            wa_full_q  <= wa_full_d;
            wa_idx_q   <= wa_idx_d;
            wd_full_q  <= wd_full_d;
            wd_dat_q   <= wd_dat_d;
            wd_msk_q   <= wd_msk_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_dat_q <= '0;
        end else if (pop) begin
            rd_dat_q <= mem[fifo_q[rd_ptr_q]];
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= ca_idx;
    end

    always_ff @(posedge clock) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_msk[b]) mem[cm_idx][8*b +: 8] <= cm_dat[8*b +: 8];
            end
        end
    end

endmodule
